// File: rtl/down_counter_ld.sv
// down_counter_ld
//   Loadable, cascadable down counter with borrow-out. A value loaded with
//   `ld` counts toward zero while `cnt` is high. At zero it either reloads
//   the last loaded value (auto-reload) or stops and pulses `done` (one-shot).
//   It can be used as a programmable interval timer or as a frequency divider.
//
// Ports
//   clock      : sole clock, rising edge
//   reset      : synchronous, active-high, highest priority
//   ld         : load strobe, captures pin into count and reload register
//   pin[n-1:0] : parallel load value
//   cnt        : count enable (borrow-in of a cascade)
//   autoreload : 1 = restart from reload value at terminal count, 0 = one-shot
//   out[n-1:0] : current count (registered)
//   bo         : borrow-out (combinational), feeds cnt of the next stage
//   busy       : high while running (registered)
//   done       : one-cycle pulse after a one-shot expiry (registered)
module down_counter_ld #(
   parameter int n = 4
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         ld,
   input  logic [n-1:0] pin,
   input  logic         cnt,
   input  logic         autoreload,
   output logic [n-1:0] out,
   output logic         bo,
   output logic         busy,
   output logic         done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t         state_q, state_d;
   logic [n-1:0]   out_q,   out_d;
   logic [n-1:0]   rl_q,    rl_d;
   logic           busy_q,  busy_d;
   logic           done_q,  done_d;
   logic           term_cnt;

   // Terminal count: an enabled cycle in RUN with the count already at zero.
   assign term_cnt = (state_q == RUN) && cnt && (out_q == '0);

   // Borrow is gated by ld and reset so it drops in the same cycle either
   // takes over; downstream stages never see a borrow that will not happen.
   assign bo = term_cnt && !ld && !reset;

   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      rl_d    = rl_q;
      done_d  = 1'b0;
      if (ld) begin
         out_d   = pin;
         rl_d    = pin;
         state_d = RUN;
      end else if ((state_q == RUN) && cnt) begin
         if (out_q != '0) begin
            out_d = out_q - 1'b1;
         end else if (autoreload) begin
            out_d = rl_q;
         end else begin
            // One-shot expiry: count stays at zero.
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
      busy_d = (state_d == RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         out_q   <= '0;
         rl_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         rl_q    <= rl_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: doc/down_counter_ld.md
# down_counter_ld

Loadable, cascadable n-bit down counter with borrow-out. It is the counterpart of the team's up counter with carry-out (`co`): the up counter counts toward all-ones and signals carry; this block counts a loaded value toward zero and signals borrow. It serves as a programmable interval timer or frequency divider. Two modes are supported: one-shot (stop at zero) and auto-reload (restart from the last loaded value).

## Interface
- `n`, default 4: counter width in bits.

- `clock`  in  1  sole clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high; highest priority.
- `ld`  in  1  load strobe; captures `pin` into counter and reload register.
- `pin`  in  n  parallel load value.
- `cnt`  in  1  count enable (borrow-in when cascaded).
- `autoreload`  in  1  1 = reload `pin`-captured value at terminal count; 0 = one-shot. Sampled on the terminal-count edge.
- `out`  out  n  current count value (registered).
- `bo`  out  1  borrow-out, combinational.
- `busy`  out  1  high while in RUN (registered).
- `done`  out  1  one-cycle registered pulse at one-shot expiry.

## Operation
- Internal state:
  - FSM: IDLE, RUN.
  - Reload register `rl[n-1:0]`.
- Priority per edge: `reset` > `ld` > count.
- Reset (synchronous): `out`=0, `rl`=0, state=IDLE, `busy`=0, `done`=0.
- `ld`=1 (any state):
  - `out`←`pin`, `rl`←`pin`, state←RUN, `done`←0.
  - `cnt` is ignored that cycle.
- IDLE:
  - `out` holds and `cnt` is ignored.
  - `bo`=0 and `busy`=0.
- RUN, `cnt`=0: hold everything.
- RUN, `cnt`=1, `out`≠0: `out`←`out`−1.
- RUN, `cnt`=1, `out`=0 (terminal count):
  - `autoreload`=1: `out`←`rl`, stay RUN, `done` stays 0.
  - `autoreload`=0: `out` stays 0, state←IDLE, `done`←1 for one cycle.
- `bo` = (state==RUN) & `cnt` & (`out`==0) & ~`ld` & ~`reset`. Purely combinational, so it is usable as `cnt` of the next stage in a cascade.
- `done` is cleared on every edge on which it is not being set.
- Arithmetic: unsigned, modulo 2^n. The decrement never wraps below 0, because 0 is always the terminal count.
- Period: in auto-reload, with `cnt` held high, the period is `rl`+1 cycles per `bo` pulse. Loading `pin`=0 gives `bo` every enabled cycle. One-shot with `pin`=0 expires on the first enabled cycle.

## Timing
- Latency:
  - `ld` → `out`: 1 clock.
  - Terminal count → `done`: 1 clock (the edge after `bo` was high).
  - `busy` follows state with 1-clock latency from `ld`/expiry.
- `bo` is valid in the same cycle as `out`==0 & `cnt`, before the edge. The downstream stage samples it on that edge.
- Simultaneous `ld` and terminal count:
  - `ld` wins: `bo`=0, no reload, no `done`.
  - The new `pin` is counted from the next cycle.
- `reset` mid-RUN: the next edge forces the reset values. A pending `done` is suppressed and `bo` drops immediately (combinational gating).
- `autoreload` change mid-count takes effect only at the next terminal count.
- Cascade: stage k `cnt` = stage k−1 `bo`. Chained `bo` forms a combinational ripple through all stages.

## Test plan
- Reset: hold `reset`=1 for 2 edges with `cnt`=1 and `ld`=1 → `out`=0, `busy`=0, `done`=0, `bo`=0 throughout.
- One-shot, n=4: `ld` with `pin`=5, then `cnt`=1 continuously.
  - `out` sequence 5,4,3,2,1,0.
  - `bo` high in the cycle `out`=0.
  - `done` high exactly 1 cycle after, then `busy`=0.
  - `out` stays 0 with further `cnt`.
- Auto-reload: `pin`=3, `autoreload`=1, `cnt`=1 for 20 cycles → `out` 3,2,1,0,3,2,… and a `bo` pulse every 4 cycles. `done` never asserts.
- Gated count: `pin`=15, `cnt` toggling 1/0 each cycle → `out` decrements on every other edge only, reaching 0 after 30 edges (15 decrements).
- `ld` collision: with `out`=0 and `cnt`=1 in RUN, assert `ld` with `pin`=9 → `bo`=0 that cycle, next `out`=9, no `done`.
- Reset mid-run: `pin`=12, count to `out`=7, assert `reset` for 1 cycle → `out`=0, IDLE. Subsequent `cnt`=1 leaves `out`=0 and `bo`=0 until the next `ld`.
